// File: rtl/psg_pan_mixer_pkg.sv
// Shared definitions for the PSG pan mixer: pan mode encodings, mixer FSM
// states, the per-channel pan routing table and the accumulator width rule.
package mixer_pkg;

    localparam logic [1:0] MIX_MONO = 2'b00;
    localparam logic [1:0] MIX_ABC  = 2'b01;
    localparam logic [1:0] MIX_ACB  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_LOAD  = 2'd2
    } mix_state_t;

    // Returns {to_l, to_r} for channel idx under the given pan mode.
    // Channels 3 and up, mono and the reserved code all feed both sides.
    function automatic logic [1:0] pan_route(input logic [1:0] mode, input int unsigned idx);
        logic [1:0] route;
        route = 2'b11;
        if (mode == MIX_ABC) begin
            if (idx == 0)      route = 2'b10;
            else if (idx == 2) route = 2'b01;
        end else if (mode == MIX_ACB) begin
            if (idx == 0)      route = 2'b10;
            else if (idx == 1) route = 2'b01;
        end
        return route;
    endfunction

    // Wide enough that summing every channel at full scale cannot wrap.
    function automatic int acc_width(input int ch_w, input int num_ch);
        return ch_w + $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/psg_pan_mixer_sigma_delta_dac.sv
// First-order sigma-delta DAC: the carry out of a W-bit phase accumulator
// gives a 1-bit stream whose density of ones is pcm / 2^W.
module sigma_delta_dac #(
    parameter int W = 10
) (
    input  logic         clk_24,
    input  logic         reset,
    input  logic [W-1:0] i_pcm,
    output logic         o_bit
);

    logic [W:0] r_integ;

    // Accumulate the sample each cycle, dropping the previous carry.
    always_ff @(posedge clk_24) begin
        if (reset) begin
            r_integ <= '0;
        end else begin
            r_integ <= {1'b0, r_integ[W-1:0]} + {1'b0, i_pcm};
        end
    end

    assign o_bit = r_integ[W];

endmodule

// File: rtl/psg_pan_mixer.sv
// PSG stereo pan mixer: snapshots NUM_CH channel levels on i_sample_ce,
// accumulates one channel per cycle into left/right sums according to the
// pan mode, saturates to OUT_W bits and feeds two sigma-delta DACs.
// Optional master attenuation (right shift by i_vol_shift) is built only
// when MIXER_VOLUME_EN is defined.
module psg_pan_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 8,
    parameter int OUT_W  = 10
) (
    input  logic                   clk_24,
    input  logic                   reset,
    input  logic                   i_sample_ce,
    input  logic [1:0]             i_mode,
    input  logic [NUM_CH*CH_W-1:0] i_chan_in,
    input  logic [2:0]             i_vol_shift,
    output logic [OUT_W-1:0]       o_pcm_l,
    output logic [OUT_W-1:0]       o_pcm_r,
    output logic                   o_pcm_valid,
    output logic                   o_busy,
    output logic                   o_overrun,
    output logic                   o_audio_l,
    output logic                   o_audio_r
);

    localparam int ACC_W = acc_width(CH_W, NUM_CH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    mix_state_t             r_state;
    logic [NUM_CH*CH_W-1:0] r_chan_snap;
    logic [1:0]             r_mode_snap;
    logic [IDX_W-1:0]       r_idx;
    logic [ACC_W-1:0]       r_acc_l;
    logic [ACC_W-1:0]       r_acc_r;
    logic [OUT_W-1:0]       r_pcm_l;
    logic [OUT_W-1:0]       r_pcm_r;
    logic                   r_pcm_valid;
    logic                   r_busy;
    logic                   r_overrun;

    logic [CH_W-1:0]  w_chan [NUM_CH];
    logic [ACC_W-1:0] w_level;
    logic [1:0]       w_route;
    logic [OUT_W-1:0] w_sat_l;
    logic [OUT_W-1:0] w_sat_r;
    logic [OUT_W-1:0] w_out_l;
    logic [OUT_W-1:0] w_out_r;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_chan[gi] = r_chan_snap[gi*CH_W +: CH_W];
        end
    endgenerate

    assign w_level = ACC_W'(w_chan[r_idx]);
    assign w_route = pan_route(r_mode_snap, 32'(r_idx));

    // Clamp only when the accumulator can exceed the output range.
    generate
        if (ACC_W > OUT_W) begin : g_sat
            assign w_sat_l = (|r_acc_l[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : r_acc_l[OUT_W-1:0];
            assign w_sat_r = (|r_acc_r[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : r_acc_r[OUT_W-1:0];
        end else begin : g_ext
            assign w_sat_l = OUT_W'(r_acc_l);
            assign w_sat_r = OUT_W'(r_acc_r);
        end
    endgenerate

`ifdef MIXER_VOLUME_EN
    assign w_out_l = w_sat_l >> i_vol_shift;
    assign w_out_r = w_sat_r >> i_vol_shift;
`else
    logic w_unused_vol;
    assign w_unused_vol = ^i_vol_shift;
    assign w_out_l = w_sat_l;
    assign w_out_r = w_sat_r;
`endif

    // Mix sequencer: snapshot, per-channel accumulate, then publish the sample.
    always_ff @(posedge clk_24) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_chan_snap <= '0;
            r_mode_snap <= MIX_MONO;
            r_idx       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_pcm_l     <= '0;
            r_pcm_r     <= '0;
            r_pcm_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_pcm_valid <= 1'b0;
            if (i_sample_ce && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_sample_ce) begin
                        r_chan_snap <= i_chan_in;
                        r_mode_snap <= i_mode;
                        r_acc_l     <= '0;
                        r_acc_r     <= '0;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_route[1]) r_acc_l <= r_acc_l + w_level;
                    if (w_route[0]) r_acc_r <= r_acc_r + w_level;
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_pcm_l     <= w_out_l;
                    r_pcm_r     <= w_out_r;
                    r_pcm_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sigma_delta_dac #(.W(OUT_W)) u_dac_l (
        .clk_24 (clk_24),
        .reset  (reset),
        .i_pcm  (r_pcm_l),
        .o_bit  (o_audio_l)
    );

    sigma_delta_dac #(.W(OUT_W)) u_dac_r (
        .clk_24 (clk_24),
        .reset  (reset),
        .i_pcm  (r_pcm_r),
        .o_bit  (o_audio_r)
    );

    assign o_pcm_l     = r_pcm_l;
    assign o_pcm_r     = r_pcm_r;
    assign o_pcm_valid = r_pcm_valid;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;

endmodule
